// File: rtl/btb_pkg.sv
// Shared types and widths for the BTB update controller slice.
// Widths here match the default geometry; the top re-derives them from its parameters.
package btb_pkg;

   localparam int B_SETS = 3;
   localparam int WAYS   = 4;
   localparam int IDX_W  = B_SETS;
   localparam int TAG_W  = 30 - B_SETS;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } btb_update_t;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      PROBE,
      RESOLVE
   } btb_state_e;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolved-branch update channel from execute into the BTB update controller.
interface btb_update_ctrl_if;

   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;

   modport master (output upd_valid, output upd_pc, output upd_target, output upd_taken,
                   input upd_ready);
   modport slave  (input upd_valid, input upd_pc, input upd_target, input upd_taken,
                   output upd_ready);

endinterface

// File: rtl/btb_upd_fifo.sv
// Small power-of-two FIFO buffering resolved-branch updates ahead of the probe/write pipeline.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int depth = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  btb_update_t din,
   output btb_update_t dout,
   output logic        full,
   output logic        empty
);

   localparam int PW = (depth > 1) ? $clog2(depth) : 1;

   btb_update_t       mem [depth];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (PW+1)'(depth));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Payload storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB tag/target/valid writes and pLRU updates for resolved branches,
// and sweeps the whole array invalid after reset or flush.
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int b_sets     = B_SETS,
   parameter int way        = WAYS,
   parameter int fifo_depth = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   btb_update_ctrl_if.slave     upd,
   output logic                 probe_req,
   output logic [b_sets-1:0]    probe_index,
   output logic [29-b_sets:0]   probe_tag,
   input  logic                 probe_hit,
   input  logic [1:0]           probe_way,
   input  logic [1:0]           plru_victim,
   output logic                 plru_load,
   output logic [b_sets-1:0]    plru_w_index,
   output logic [1:0]           plru_w_mru,
   output logic                 btb_we,
   output logic [b_sets-1:0]    btb_index,
   output logic [1:0]           btb_way,
   output logic [29-b_sets:0]   btb_tag,
   output logic [31:0]          btb_target,
   output logic                 btb_valid_bit,
   output logic                 init_busy
);

   localparam int CNT_W = b_sets + 2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((2**b_sets) * way - 1);

   btb_state_e        state_q;
   btb_state_e        state_d;
   logic [CNT_W-1:0]  cnt_q;
   btb_update_t       entry_q;
   btb_update_t       upd_in;
   btb_update_t       head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [1:0]        way_sel;
   logic              unused_pc_bits;

   assign upd_in        = '{pc: upd.upd_pc, target: upd.upd_target, taken: upd.upd_taken};
   assign upd.upd_ready = !full && !flush && !rst;
   assign push          = upd.upd_valid && upd.upd_ready;
   assign pop           = !flush && !empty && (state_q == IDLE || state_q == RESOLVE);
   assign init_busy     = (state_q == INIT);
   assign unused_pc_bits = ^entry_q.pc[1:0];

   btb_upd_fifo #(.depth(fifo_depth)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (push),
      .pop   (pop),
      .din   (upd_in),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // State, sweep counter and the entry currently being probed/written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         entry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == INIT && !flush) ? cnt_q + 1'b1 : '0;
         if (flush) begin
            entry_q <= '0;
         end else if (pop) begin
            entry_q <= head;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (cnt_q == LAST) state_d = IDLE;
         IDLE:    if (!empty) state_d = PROBE;
         PROBE:   state_d = RESOLVE;
         RESOLVE: state_d = empty ? IDLE : PROBE;
         default: state_d = INIT;
      endcase
      if (flush) begin
         state_d = INIT;
      end
   end

   // The pLRU victim is only consulted on a taken miss, the same cycle plru_load fires.
   always_comb begin
      probe_req     = 1'b0;
      probe_index   = '0;
      probe_tag     = '0;
      plru_load     = 1'b0;
      plru_w_index  = '0;
      plru_w_mru    = '0;
      btb_we        = 1'b0;
      btb_index     = '0;
      btb_way       = '0;
      btb_tag       = '0;
      btb_target    = '0;
      btb_valid_bit = 1'b0;
      way_sel       = '0;
      if (!rst) begin
         case (state_q)
            INIT: begin
               btb_we    = 1'b1;
               btb_index = cnt_q[CNT_W-1:2];
               btb_way   = cnt_q[1:0];
            end
            PROBE: begin
               probe_req   = 1'b1;
               probe_index = entry_q.pc[b_sets+1:2];
               probe_tag   = entry_q.pc[31:b_sets+2];
            end
            RESOLVE: begin
               if (!flush) begin
                  if (entry_q.taken) begin
                     way_sel       = probe_hit ? probe_way : plru_victim;
                     btb_we        = 1'b1;
                     btb_valid_bit = 1'b1;
                     btb_index     = entry_q.pc[b_sets+1:2];
                     btb_way       = way_sel;
                     btb_tag       = entry_q.pc[31:b_sets+2];
                     btb_target    = entry_q.target;
                     plru_load     = 1'b1;
                     plru_w_index  = entry_q.pc[b_sets+1:2];
                     plru_w_mru    = way_sel;
                  end else if (probe_hit) begin
                     btb_we    = 1'b1;
                     btb_index = entry_q.pc[b_sets+1:2];
                     btb_way   = probe_way;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
